rr_arbiter_4: RTL and testbench

Four-requester round-robin arbiter sharing one resource slot among requesters 0..3. Grants are registered and one-hot. The arbiter holds a grant while the holder keeps requesting, up to a bounded tenure, then rotates priority. The one-hot grant comes from a 2-to-4 decode of the registered grant index. The block sits in front of the shared decoder/select datapath and drives its enable and select lines.

---
 rtl/rr_arbiter_4_pkg.sv | 38 +++
 rtl/rr_arbiter_4_decode.sv | 22 ++
 rtl/rr_arbiter_4.sv | 113 +++++++++++
 tb/tb_rr_arbiter_4.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
// Holds state encodings, requester geometry and the rotating winner search.
// The search is purely combinational and is used by the arbiter top only.
package rr_arbiter_4_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Result of one round-robin search over the request vector.
    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] id;
    } pick_t;

    // Search req starting at ptr and moving upward, wrapping mod NUM_REQ.
    // The loop runs from the farthest offset down to offset 0, so the
    // candidate closest to ptr is the last one written and therefore wins.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [ID_W-1:0]    ptr);
        pick_t           p;
        logic [ID_W-1:0] idx;
        p = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + ID_W'(k);
            if (req[idx]) begin
                p.found = 1'b1;
                p.id    = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_decode.sv
// 2-to-4 one-hot decoder with enable; drives the grant lines from the registered index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output is all zero whenever en is low.
//
// Ports:
//   en  input  1  decode enable (gnt_valid)
//   I   input  2  index to decode (gnt_id)
//   y   output 4  one-hot result, zero when en=0
module grant_decode_2_4 (
    input  logic       en,
    input  logic [1:0] I,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (en) begin
            y = 4'b0001 << I;
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with bounded tenure and registered one-hot grant.
// Latency: request before edge N is granted after edge N; handover is bubble-free.
// Backpressure: en=0 drops the grant on the next edge; no grant without a request.
//
// Ports:
//   clk        input  1  clock, all state changes on the rising edge
//   rst        input  1  synchronous active-high reset, overrides en and req
//   en         input  1  arbitration enable; low forces no grant
//   req        input  4  request vector, bit i is requester i
//   gnt        output 4  one-hot grant, all zero when gnt_valid=0
//   gnt_id     output 2  index of granted requester, holds last value when idle
//   gnt_valid  output 1  a grant is active
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid
);

    // Tenure ends on the edge where hold_cnt reaches this value.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state,    state_nxt;
    logic [ID_W-1:0]  ptr,      ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [ID_W-1:0]  id_q,     id_nxt;
    logic             vld_q,    vld_nxt;

    pick_t            pick;

    // Winner search from the current priority pointer.
    always_comb begin
        pick = rr_pick(req, ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            id_q     <= '0;
            vld_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            id_q     <= id_nxt;
            vld_q    <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        id_nxt       = id_q;
        vld_nxt      = vld_q;

        unique case (state)
            ST_IDLE: begin
                if (en && pick.found) begin
                    state_nxt    = ST_GRANT;
                    id_nxt       = pick.id;
                    vld_nxt      = 1'b1;
                    hold_cnt_nxt = '0;
                    ptr_nxt      = pick.id + ID_W'(1);
                end
            end

            ST_GRANT: begin
                if (!en) begin
                    // Drop the grant but keep ptr and gnt_id for the next round.
                    state_nxt = ST_IDLE;
                    vld_nxt   = 1'b0;
                end else if (req[id_q] && (hold_cnt < HOLD_LAST)) begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end else if (pick.found) begin
                    // ptr already points past the holder, so an expiring holder
                    // only wins again when nobody else is asking.
                    id_nxt       = pick.id;
                    hold_cnt_nxt = '0;
                    ptr_nxt      = pick.id + ID_W'(1);
                end else begin
                    state_nxt = ST_IDLE;
                    vld_nxt   = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    assign gnt_id    = id_q;
    assign gnt_valid = vld_q;

    grant_decode_2_4 u_dec (
        .en (vld_q),
        .I  (id_q),
        .y  (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [3:0] req = 4'b1111;

    logic [3:0] g1, g4, g8;
    logic [1:0] id1, id4, id8;
    logic       v1, v4, v8;

    int n_cmp = 0;
    int n_err = 0;
    bit run   = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(1), .CNT_W(8)) u_h1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(g1), .gnt_id(id1), .gnt_valid(v1));
    rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(8)) u_h4 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(g4), .gnt_id(id4), .gnt_valid(v4));
    rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(8)) u_h8 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(g8), .gnt_id(id8), .gnt_valid(v8));

    // Behavioural model: who holds the grant, how many cycles it has held,
    // and which requester gets first look at the next arbitration.
    int mh[3]    = '{1, 4, 8};
    int m_first[3];
    int m_id[3];
    int m_ten[3];
    bit m_vld[3];

    function automatic int pick_from(input logic [3:0] r, input int first);
        for (int j = 0; j < 4; j++) begin
            if (r[(first + j) % 4]) return (first + j) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int w;
            w = pick_from(req, m_first[k]);
            if (rst) begin
                m_first[k] = 0; m_id[k] = 0; m_ten[k] = 0; m_vld[k] = 0;
            end else if (!m_vld[k]) begin
                if (en && w >= 0) begin
                    m_id[k] = w; m_vld[k] = 1; m_ten[k] = 1; m_first[k] = (w + 1) % 4;
                end
            end else if (!en) begin
                m_vld[k] = 0;
            end else if (req[m_id[k]] && m_ten[k] < mh[k]) begin
                m_ten[k] = m_ten[k] + 1;
            end else if (w >= 0) begin
                m_id[k] = w; m_ten[k] = 1; m_first[k] = (w + 1) % 4;
            end else begin
                m_vld[k] = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input bit vld, input int id);
        return vld ? 4'(1 << id) : 4'b0000;
    endfunction

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (run) begin
            chk("h1_gnt", g1, onehot(m_vld[0], m_id[0]));
            chk("h1_id",  {2'b00, id1}, 4'(m_id[0]));
            chk("h1_vld", {3'b000, v1}, {3'b000, m_vld[0]});
            chk("h4_gnt", g4, onehot(m_vld[1], m_id[1]));
            chk("h4_id",  {2'b00, id4}, 4'(m_id[1]));
            chk("h4_vld", {3'b000, v4}, {3'b000, m_vld[1]});
            chk("h8_gnt", g8, onehot(m_vld[2], m_id[2]));
            chk("h8_id",  {2'b00, id8}, 4'(m_id[2]));
            chk("h8_vld", {3'b000, v8}, {3'b000, m_vld[2]});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1; en = 1'b1; req = r;
        step(1);
        rst = 1'b0;
    endtask

    logic [4:0] vec[20] = '{
        5'b1_0110, 5'b1_0110, 5'b1_0100, 5'b1_1001, 5'b0_1001,
        5'b1_1001, 5'b1_0000, 5'b1_0001, 5'b1_1110, 5'b1_1110,
        5'b1_1100, 5'b1_1000, 5'b1_1000, 5'b1_1000, 5'b1_1000,
        5'b1_1000, 5'b0_0000, 5'b1_0011, 5'b1_0010, 5'b1_0000
    };

    initial begin
        // Reset held for two cycles with everyone requesting.
        rst = 1'b1; en = 1'b1; req = 4'b1111;
        step(1);
        run = 1'b1;
        step(1);
        chk("rst_gnt", g8, 4'b0000);
        chk("rst_vld", {3'b000, v8}, 4'b0000);
        chk("rst_id",  {2'b00, id8}, 4'b0000);
        rst = 1'b0;
        step(1);
        chk("first_gnt_h8", g8, 4'b0001);

        // Rotation with MAX_HOLD=1 under continuous full request.
        chk("rot0", g1, 4'b0001);
        step(1); chk("rot1", g1, 4'b0010);
        step(1); chk("rot2", g1, 4'b0100);
        step(1); chk("rot3", g1, 4'b1000);
        step(1); chk("rot4", g1, 4'b0001);

        // Tenure limit with MAX_HOLD=8, two requesters.
        do_reset(4'b0101);
        step(1); chk("ten_a_start", g8, 4'b0001);
        step(7); chk("ten_a_last",  g8, 4'b0001);
        step(1); chk("ten_b_start", g8, 4'b0100);
        step(7); chk("ten_b_last",  g8, 4'b0100);
        step(1); chk("ten_a_again", g8, 4'b0001);

        // Release handover without a bubble.
        do_reset(4'b0011);
        step(1); chk("rel_start", g8, 4'b0001);
        step(2);
        req = 4'b0010;
        step(1);
        chk("rel_gnt", g8, 4'b0010);
        chk("rel_vld", {3'b000, v8}, 4'b0001);

        // Enable dropped for one cycle with a sole requester.
        do_reset(4'b1000);
        step(1); chk("en_start", g8, 4'b1000);
        step(2);
        en = 1'b0;
        step(1); chk("en_off", g8, 4'b0000);
        chk("en_off_id", {2'b00, id8}, 4'b0011);
        en = 1'b1;
        step(1); chk("en_back", g8, 4'b1000);
        // Sole requester keeps getting re-granted across tenure expiry.
        step(5); chk("sole_h4", g4, 4'b1000);

        // Reset in the middle of a grant.
        do_reset(4'b0100);
        step(1); chk("mid_start", g8, 4'b0100);
        rst = 1'b1; req = 4'b1111;
        step(1); chk("mid_rst", g8, 4'b0000);
        rst = 1'b0;
        step(1); chk("mid_after", g8, 4'b0001);

        // Mixed directed patterns, checked cycle by cycle against the model.
        for (int i = 0; i < 20; i++) begin
            en  = vec[i][4];
            req = vec[i][3:0];
            step(1);
        end
        req = 4'b0000;
        step(2);
        chk("drain_vld", {3'b000, v8}, 4'b0000);

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
